// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory arbiter: state encodings, default widths, requester indices.
package dm_arb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int PC_W       = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
endpackage

// File: rtl/dm_arbiter_if.sv
// Requester (M0 pipeline, M1 debug/DMA) and data-memory signals of the arbiter.
// master = requesters plus DM side, slave = the arbiter itself.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic [PC_W-1:0]   m0_pc;

    logic              m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic [PC_W-1:0]   m1_pc;

    logic [ADDR_W-1:0] dm_add;
    logic [DATA_W-1:0] dm_wd, dm_rd;
    logic [PC_W-1:0]   dm_pc;
    logic              dm_we, dm_re;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_pc,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_pc,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  dm_add, dm_wd, dm_pc, dm_we, dm_re,
        output dm_rd
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_pc,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_pc,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output dm_add, dm_wd, dm_pc, dm_we, dm_re,
        input  dm_rd
    );
endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// Combinational two-way pick: lone requester wins; a tie goes to the one not last served,
// or always to M0 when fixed priority is selected.
module rr_pick2
    import dm_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_fixed,
    output logic       o_winner,
    output logic       o_any
);
    always_comb begin
        o_any    = |i_req;
        o_winner = M0;
        if (i_req == 2'b10)
            o_winner = M1;
        else if (i_req == 2'b11 && !i_fixed)
            o_winner = ~i_last;
    end
endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates M0/M1 onto the single-port DM: grant one cycle after the sampled request, rvalid one after that.
// Optional DM_ARB_TRACE_EN prints each committed store.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);
    logic [1:0]        r_state;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [PC_W-1:0]   r_pc;
    logic              r_rvalid0, r_rvalid1, r_err0, r_err1;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    logic w_win, w_any, w_acc0, w_acc1, w_aligned, w_dm_we, w_dm_re;

    rr_pick2 u_pick (
        .i_req    ({bus.m1_req, bus.m0_req}),
        .i_last   (r_last),
        .i_fixed  (FIXED_PRIO != 0),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    assign w_acc0    = (r_state == S_ACC0);
    assign w_acc1    = (r_state == S_ACC1);
    assign w_aligned = (r_addr[1:0] == 2'b00);
    // Enables decode from the async-reset state so a reset mid-access kills the write immediately.
    assign w_dm_we   = (w_acc0 | w_acc1) & r_we & w_aligned;
    assign w_dm_re   = (w_acc0 | w_acc1) & ~r_we & w_aligned;

    // Every edge samples requests, so a grant cycle can overlap the next arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= M1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
        end else if (w_any) begin
            r_state <= (w_win == M1) ? S_ACC1 : S_ACC0;
            r_last  <= w_win;
            r_we    <= (w_win == M1) ? bus.m1_we    : bus.m0_we;
            r_addr  <= (w_win == M1) ? bus.m1_addr  : bus.m0_addr;
            r_wdata <= (w_win == M1) ? bus.m1_wdata : bus.m0_wdata;
            r_pc    <= (w_win == M1) ? bus.m1_pc    : bus.m0_pc;
        end else begin
            r_state <= S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_acc0;
            r_rvalid1 <= w_acc1;
            r_err0    <= w_acc0 & ~w_aligned;
            r_err1    <= w_acc1 & ~w_aligned;
            if (w_acc0 && w_dm_re)
                r_rdata0 <= bus.dm_rd;
            if (w_acc1 && w_dm_re)
                r_rdata1 <= bus.dm_rd;
        end
    end

    assign bus.m0_gnt    = w_acc0;
    assign bus.m1_gnt    = w_acc1;
    assign bus.m0_rvalid = r_rvalid0;
    assign bus.m1_rvalid = r_rvalid1;
    assign bus.m0_err    = r_err0;
    assign bus.m1_err    = r_err1;
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;
    assign bus.dm_add    = r_addr;
    assign bus.dm_wd     = r_wdata;
    assign bus.dm_pc     = r_pc;
    assign bus.dm_we     = w_dm_we;
    assign bus.dm_re     = w_dm_re;

`ifdef DM_ARB_TRACE_EN
    always @(posedge clk) begin
        if (w_dm_we)
            $display("%d@%h: *%h <= %h", $time, r_pc, r_addr, r_wdata);
    end
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: random two-master traffic plus directed reset and fixed-priority cases.
module tb_dm_arbiter;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } rq_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dm_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    dm_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus_f ();

    dm_arbiter #(.DATA_W(32), .ADDR_W(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    dm_arbiter #(.DATA_W(32), .ADDR_W(32), .FIXED_PRIO(1)) u_fix (
        .clk(clk), .reset(reset), .bus(bus_f.slave));

    // Data memory seen by the main DUT: combinational read, write at the clock edge.
    logic [31:0] mem [64] = '{default: 32'd0};
    always @(posedge clk) if (bus.dm_we) mem[bus.dm_add[7:2]] <= bus.dm_wd;
    assign bus.dm_rd   = mem[bus.dm_add[7:2]];
    assign bus_f.dm_rd = 32'd0;

    // Reference model: each master owns a disjoint 16-word region, so its responses follow issue order.
    logic [31:0] ref_mem [64] = '{default: 32'd0};
    logic [31:0] last_rd [2]  = '{default: 32'd0};
    rsp_t        expq0[$], expq1[$];
    rq_t         cur [2];
    logic [1:0]  rq_on = 2'b00;
    bit          mon_en = 0, issuing = 0;
    int          n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    task automatic apply();
        bus.m0_req = rq_on[0]; bus.m0_we = cur[0].we; bus.m0_addr = cur[0].addr;
        bus.m0_wdata = cur[0].wdata; bus.m0_pc = cur[0].pc;
        bus.m1_req = rq_on[1]; bus.m1_we = cur[1].we; bus.m1_addr = cur[1].addr;
        bus.m1_wdata = cur[1].wdata; bus.m1_pc = cur[1].pc;
    endtask

    task automatic issue(input int m);
        int   word;
        bit   mis;
        rsp_t r;
        word = m * 16 + int'($urandom_range(0, 15));
        mis  = ($urandom_range(0, 7) == 0);
        cur[m].we    = 1'($urandom_range(0, 1));
        cur[m].addr  = 32'(word * 4) | (mis ? 32'($urandom_range(1, 3)) : 32'd0);
        cur[m].wdata = $urandom;
        cur[m].pc    = $urandom;
        if (!mis) begin
            if (cur[m].we) ref_mem[word] = cur[m].wdata;
            else           last_rd[m]    = ref_mem[word];
        end
        r.err   = mis;
        r.rdata = last_rd[m];
        if (m == 0) expq0.push_back(r);
        else        expq1.push_back(r);
        rq_on[m] = 1'b1;
    endtask

    // A request is consumed when its grant is seen; a new one may be presented in the same cycle.
    task automatic drive_step();
        logic [1:0] g;
        g = {bus.m1_gnt, bus.m0_gnt};
        for (int m = 0; m < 2; m++) begin
            if (rq_on[m] && g[m]) rq_on[m] = 1'b0;
            if (!rq_on[m] && issuing && $urandom_range(0, 3) != 0) issue(m);
        end
        apply();
    endtask

    // Monitor: checks grant order, grant-to-rvalid latency, DM drive and responses against the queues.
    initial begin
        logic [1:0] s_req, g, rv, exp_g;
        logic [1:0] pend;
        logic       last_w;
        logic       al;
        rq_t        s_r [2];
        rsp_t       got, want;
        pend = 2'b00;
        last_w = 1'b1;
        forever begin
            @(posedge clk);
            s_req = {bus.m1_req, bus.m0_req};
            s_r   = cur;
            if (reset) begin
                last_w = 1'b1;
                pend   = 2'b00;
            end
            @(negedge clk);
            if (mon_en && !reset) begin
                g  = {bus.m1_gnt, bus.m0_gnt};
                rv = {bus.m1_rvalid, bus.m0_rvalid};
                for (int m = 0; m < 2; m++) begin
                    chk1("rvalid_timing", rv[m], pend[m]);
                    if (rv[m]) begin
                        got = (m == 0) ? {bus.m0_err, bus.m0_rdata} : {bus.m1_err, bus.m1_rdata};
                        if ((m == 0 && expq0.size() == 0) || (m == 1 && expq1.size() == 0)) begin
                            n_tot++;
                            $display("FAIL unexpected_rvalid: master %0d got rvalid, required none", m);
                        end else begin
                            if (m == 0) want = expq0.pop_front();
                            else        want = expq1.pop_front();
                            chk1("rsp_err", got.err, want.err);
                            chk("rsp_rdata", got.rdata, want.rdata);
                        end
                    end
                end
                case (s_req)
                    2'b01:   exp_g = 2'b01;
                    2'b10:   exp_g = 2'b10;
                    2'b11:   exp_g = last_w ? 2'b01 : 2'b10;
                    default: exp_g = 2'b00;
                endcase
                chk("grant", 32'(g), 32'(exp_g));
                if (exp_g != 2'b00) last_w = exp_g[1];
                for (int m = 0; m < 2; m++) begin
                    if (g[m]) begin
                        al = (s_r[m].addr[1:0] == 2'b00);
                        chk("dm_add", bus.dm_add, s_r[m].addr);
                        chk1("dm_we", bus.dm_we, s_r[m].we & al);
                        chk1("dm_re", bus.dm_re, ~s_r[m].we & al);
                    end
                end
                pend = g;
            end
        end
    end

    initial begin
        int t;
        cur[0] = '0;
        cur[1] = '0;
        apply();
        bus_f.m0_req = 1'b0; bus_f.m0_we = 1'b0; bus_f.m0_addr = 32'h0;
        bus_f.m0_wdata = 32'h0; bus_f.m0_pc = 32'h0;
        bus_f.m1_req = 1'b0; bus_f.m1_we = 1'b0; bus_f.m1_addr = 32'h4;
        bus_f.m1_wdata = 32'h0; bus_f.m1_pc = 32'h0;

        repeat (3) @(negedge clk);
        chk1("rst_m0_gnt", bus.m0_gnt, 1'b0);
        chk1("rst_m1_gnt", bus.m1_gnt, 1'b0);
        chk1("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
        chk1("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
        chk1("rst_m0_err", bus.m0_err, 1'b0);
        chk1("rst_m1_err", bus.m1_err, 1'b0);
        chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
        chk("rst_m1_rdata", bus.m1_rdata, 32'h0);
        chk1("rst_dm_we", bus.dm_we, 1'b0);
        chk1("rst_dm_re", bus.dm_re, 1'b0);
        chk("rst_dm_add", bus.dm_add, 32'h0);
        chk("rst_dm_wd", bus.dm_wd, 32'h0);
        chk("rst_dm_pc", bus.dm_pc, 32'h0);
        reset = 1'b0;

        // Reset pulse in the middle of an M0 store cycle.
        cur[0] = '{we: 1'b1, addr: 32'h10, wdata: 32'hAA, pc: 32'h100};
        rq_on  = 2'b01;
        apply();
        @(negedge clk);
        chk1("t1_gnt", bus.m0_gnt, 1'b1);
        chk1("t1_we_before_rst", bus.dm_we, 1'b1);
        #2 reset = 1'b1;
        #1 chk1("t1_we_async_drop", bus.dm_we, 1'b0);
        rq_on = 2'b00;
        apply();
        @(negedge clk);
        chk("t1_mem_unchanged", mem[4], 32'h0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk1("t1_no_rvalid", bus.m0_rvalid, 1'b0);
        end

        // Fixed priority: M0 holds the port while it keeps requesting.
        bus_f.m0_req = 1'b1;
        bus_f.m1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1("fix_m0_gnt", bus_f.m0_gnt, 1'b1);
            chk1("fix_m1_gnt", bus_f.m1_gnt, 1'b0);
        end
        bus_f.m0_req = 1'b0;
        @(negedge clk);
        chk1("fix_m1_after_drop", bus_f.m1_gnt, 1'b1);
        chk1("fix_m0_after_drop", bus_f.m0_gnt, 1'b0);
        bus_f.m1_req = 1'b0;
        @(negedge clk);
        chk1("fix_idle", bus_f.m1_gnt, 1'b0);

        // Random traffic from both masters under the scoreboard.
        reset   = 1'b1;
        mon_en  = 1;
        issuing = 1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            drive_step();
        end
        issuing = 0;
        t = 0;
        while ((rq_on != 2'b00 || expq0.size() != 0 || expq1.size() != 0) && t < 200) begin
            @(negedge clk);
            drive_step();
            t++;
        end
        repeat (2) @(negedge clk);
        chk("drain_q0", 32'(expq0.size()), 32'd0);
        chk("drain_q1", 32'(expq1.size()), 32'd0);
        chk1("drain_req", rq_on != 2'b00, 1'b0);
        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
